shift_rows_stream: RTL

SHIFT_ROWS_STREAM -- requirements
Module: shift_rows_stream

---
 rtl/aes_pkg.sv | 45 ++++
 rtl/sr_bank.sv | 52 +++++
 rtl/shift_rows_stream.sv | 119 +++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared AES byte-stream definitions: block size, permutation mode and the
// helpers that map output positions to input positions.
package aes_pkg;

  localparam int STATE_BYTES = 16;

  typedef enum logic [1:0] {
    SHIFT  = 2'b00,
    INV    = 2'b01,
    BYPASS = 2'b10
  } mode_e;

  // Raw mode field to internal mode; inverse folds to bypass when not built.
  function automatic mode_e decode_mode(input logic [1:0] raw, input logic inv_en);
    mode_e m;
    case (raw)
      2'b00:   m = SHIFT;
      2'b01:   m = inv_en ? INV : BYPASS;
      default: m = BYPASS;
    endcase
    return m;
  endfunction

  // Input byte index feeding output byte j (j = row + 4*col, column-major).
  function automatic logic [3:0] src_index(input mode_e mode, input logic [3:0] j);
    logic [1:0] r;
    logic [1:0] c;
    logic [1:0] cs;
    r = j[1:0];
    c = j[3:2];
    case (mode)
      SHIFT:   cs = c + r;
      INV:     cs = c - r;
      default: cs = c;
    endcase
    return {cs, r};
  endfunction

  // Accepted-byte count at which output byte j may be loaded. The first
  // output bytes are held back so the block then streams without gaps.
  function automatic logic [4:0] ready_count(input logic [3:0] j);
    return (j < 4'd3) ? ({1'b0, j} + 5'd13) : 5'd16;
  endfunction

endpackage

// File: rtl/sr_bank.sv
// One 16-entry block buffer: storage, write index, occupied/full flags and
// the mode captured with byte 0 of the block being written.
module sr_bank
  import aes_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  mode_e         wr_mode,
  input  logic          clr,
  input  logic [3:0]    rd_addr,
  output logic [DW-1:0] rd_data,
  output logic [3:0]    wr_idx,
  output logic          occupied,
  output logic          full,
  output mode_e         mode
);

  logic [DW-1:0] mem [STATE_BYTES];

  // Byte storage; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

  // Fill tracking: occupied from byte 0, full after byte 15, cleared on release.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_idx   <= '0;
      occupied <= 1'b0;
      full     <= 1'b0;
      mode     <= SHIFT;
    end else if (clr) begin
      wr_idx   <= '0;
      occupied <= 1'b0;
      full     <= 1'b0;
    end else if (wr_en) begin
      wr_idx <= wr_idx + 4'd1;
      if (wr_idx == 4'd0) begin
        occupied <= 1'b1;
        mode     <= wr_mode;
      end
      if (wr_idx == 4'd15) full <= 1'b1;
    end
  end

endmodule

// File: rtl/shift_rows_stream.sv
// Streaming AES ShiftRows / InvShiftRows / bypass permuter. Two ping-pong
// block buffers feed a registered output holding stage; output byte j is
// loaded once enough of its block has arrived, forwarding in_data when the
// needed byte is being written on the same edge.
module shift_rows_stream
  import aes_pkg::*;
#(
  parameter int DW     = 8,
  parameter int INV_EN = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic [1:0]    in_mode,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_last
);

  logic          wr_bank;
  logic          rd_bank;
  logic          out_bank;
  logic [3:0]    rd_idx;
  logic          out_valid_q;
  logic          out_last_q;
  logic [DW-1:0] out_data_q;

  logic [1:0]    bk_wr_en;
  logic [1:0]    bk_clr;
  logic [1:0]    bk_occ;
  logic [1:0]    bk_full;
  logic [3:0]    bk_wr_idx  [2];
  logic [DW-1:0] bk_rd_data [2];
  mode_e         bk_mode    [2];

  mode_e         wr_mode_dec;
  logic [3:0]    rd_addr;
  logic          in_fire;
  logic          out_fire;
  logic          same_bank_wr;
  logic          fwd;
  logic          eligible;
  logic          load;
  logic [4:0]    rd_count;
  logic [DW-1:0] load_data;

  assign wr_mode_dec = decode_mode(in_mode, INV_EN != 0);

  for (genvar b = 0; b < 2; b++) begin : g_bank
    sr_bank #(.DW(DW)) u_bank (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (bk_wr_en[b]),
      .wr_data  (in_data),
      .wr_mode  (wr_mode_dec),
      .clr      (bk_clr[b]),
      .rd_addr  (rd_addr),
      .rd_data  (bk_rd_data[b]),
      .wr_idx   (bk_wr_idx[b]),
      .occupied (bk_occ[b]),
      .full     (bk_full[b]),
      .mode     (bk_mode[b])
    );
  end

  // Only a completely written bank that is still draining blocks the input.
  assign in_ready = !rst && !(bk_occ[wr_bank] && bk_full[wr_bank]);
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid_q && out_ready;

  // Bank strobes, read address mapping and load eligibility.
  always_comb begin
    bk_wr_en          = '0;
    bk_wr_en[wr_bank] = in_fire;
    bk_clr            = '0;
    bk_clr[out_bank]  = out_fire && out_last_q;
    rd_addr           = src_index(bk_mode[rd_bank], rd_idx);
    same_bank_wr      = in_fire && (wr_bank == rd_bank);
    fwd               = same_bank_wr && (bk_wr_idx[rd_bank] == rd_addr);
    load_data         = fwd ? in_data : bk_rd_data[rd_bank];
    rd_count          = bk_full[rd_bank] ? 5'd16 : {1'b0, bk_wr_idx[rd_bank]};
    eligible          = (rd_count + (same_bank_wr ? 5'd1 : 5'd0)) >= ready_count(rd_idx);
    load              = eligible && (!out_valid_q || out_ready);
  end

  // Bank pointers, read index and the output holding register.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bank     <= 1'b0;
      rd_bank     <= 1'b0;
      out_bank    <= 1'b0;
      rd_idx      <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else begin
      if (in_fire && (bk_wr_idx[wr_bank] == 4'd15)) wr_bank <= !wr_bank;
      if (load) begin
        out_valid_q <= 1'b1;
        out_data_q  <= load_data;
        out_last_q  <= (rd_idx == 4'd15);
        out_bank    <= rd_bank;
        rd_idx      <= rd_idx + 4'd1;
        if (rd_idx == 4'd15) rd_bank <= !rd_bank;
      end else if (out_fire) begin
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_q && !rst;
  assign out_last  = out_last_q && !rst;
  assign out_data  = rst ? '0 : out_data_q;

endmodule
